// File: rtl/output_port_arbiter_pkg.sv
// Shared router constants: port count and indices, arbiter state encoding, credit defaults.
package output_port_arbiter_pkg;

  localparam int unsigned NUM_PORTS = 5;

  localparam int unsigned PORT_LOCAL = 0;
  localparam int unsigned PORT_NORTH = 1;
  localparam int unsigned PORT_EAST  = 2;
  localparam int unsigned PORT_SOUTH = 3;
  localparam int unsigned PORT_WEST  = 4;

  localparam int unsigned CREDIT_DEPTH = 4;
  localparam int unsigned CNT_W        = 3;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/output_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from rr_ptr_i+1,
// wrapping modulo NUM_PORTS. Output is one-hot, or zero when nothing is requested.
module output_port_arbiter_rr_pick #(
  parameter int unsigned NUM_PORTS = output_port_arbiter_pkg::NUM_PORTS,
  parameter int unsigned PTR_W     = 3
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PTR_W-1:0]     rr_ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    // The pointer itself is visited last, so the previous owner has lowest priority.
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx = PTR_W'((32'(rr_ptr_i) + i) % NUM_PORTS);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output-port switch allocator: round-robin grant held for a whole wormhole packet,
// with flit movement gated by a downstream credit counter.
module output_port_arbiter #(
  parameter int unsigned NUM_PORTS    = output_port_arbiter_pkg::NUM_PORTS,
  parameter int unsigned CREDIT_DEPTH = output_port_arbiter_pkg::CREDIT_DEPTH,
  parameter int unsigned CNT_W        = output_port_arbiter_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0] req_tail_i,
  input  logic                 credit_in_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic                 xfer_o,
  output logic [CNT_W-1:0]     credit_cnt_o,
  output logic                 credit_err_o
);

  import output_port_arbiter_pkg::*;

  localparam int unsigned      PTR_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PTR_W-1:0] PTR_RST    = PTR_W'(NUM_PORTS - 1);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDIT_DEPTH);

  logic [0:0]           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     credit_cnt_q, credit_cnt_d;
  logic                 credit_err_q, credit_err_d;

  logic [NUM_PORTS-1:0] pick;
  logic [PTR_W-1:0]     owner_idx;
  logic                 owner_tail;

  output_port_arbiter_rr_pick #(
    .NUM_PORTS(NUM_PORTS),
    .PTR_W    (PTR_W)
  ) u_rr_pick (
    .req_i   (req_i),
    .rr_ptr_i(rr_ptr_q),
    .gnt_o   (pick)
  );

  // grant_q is zero in IDLE, so xfer is only ever raised while LOCKED.
  assign xfer_o = (state_q == ST_LOCKED) && (|(grant_q & req_i)) && (credit_cnt_q != '0);
  assign owner_tail = |(grant_q & req_tail_i);

  always_comb begin
    owner_idx = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant_q[i]) owner_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          grant_d = pick;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (xfer_o && owner_tail) begin
          rr_ptr_d = owner_idx;
          grant_d  = '0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    credit_cnt_d = credit_cnt_q;
    credit_err_d = credit_err_q;
    case ({xfer_o, credit_in_i})
      2'b10: credit_cnt_d = credit_cnt_q - CNT_W'(1);
      2'b01: begin
        // A credit returned into a full counter means downstream lost track: saturate and flag.
        if (credit_cnt_q == CREDIT_MAX) credit_err_d = 1'b1;
        else                            credit_cnt_d = credit_cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= PTR_RST;
      credit_cnt_q <= CREDIT_MAX;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      credit_cnt_q <= credit_cnt_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign grant_o      = grant_q;
  assign credit_cnt_o = credit_cnt_q;
  assign credit_err_o = credit_err_q;

  grant_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed scenarios plus randomized traffic checked
// against a packet-level reference model.
module tb_output_port_arbiter;

  localparam int N     = 5;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req;
  logic [4:0] tail;
  logic       cin;
  logic [4:0] grant;
  logic       xfer;
  logic [2:0] credit_cnt;
  logic       credit_err;

  always #5 clk = ~clk;

  output_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .req_tail_i  (tail),
    .credit_in_i (cin),
    .grant_o     (grant),
    .xfer_o      (xfer),
    .credit_cnt_o(credit_cnt),
    .credit_err_o(credit_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner = -1 when no packet holds the port.
  int         m_owner;
  int         m_last;
  int         m_cred;
  bit         m_err;
  logic [4:0] exp_grant;
  logic       exp_xfer;
  logic [2:0] exp_cnt;
  logic       exp_err;

  logic [4:0] rr_seq [6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};

  function automatic int rr_winner(logic [4:0] r, int last);
    for (int i = 1; i <= N; i++) begin
      int idx = (last + i) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function void model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_cred  = DEPTH;
    m_err   = 1'b0;
  endfunction

  function void model_expect();
    exp_grant = (m_owner < 0) ? 5'b0 : 5'(1 << m_owner);
    exp_xfer  = (m_owner >= 0) && req[m_owner] && (m_cred > 0);
    exp_cnt   = 3'(m_cred);
    exp_err   = m_err;
  endfunction

  function void model_update();
    if (m_owner < 0) begin
      if (req != 5'b0) m_owner = rr_winner(req, m_last);
    end else if (exp_xfer && tail[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end
    if (exp_xfer && !cin) m_cred--;
    else if (cin && !exp_xfer) begin
      if (m_cred == DEPTH) m_err = 1'b1;
      else                 m_cred++;
    end
  endfunction

  // Called at a falling edge; outputs are sampled 1 time unit later.
  task apply(input logic [4:0] r, input logic [4:0] t, input logic c);
    req  = r;
    tail = t;
    cin  = c;
    model_expect();
    #1;
  endtask

  task tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task do_reset();
    rst  = 1'b1;
    req  = '0;
    tail = '0;
    cin  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task test_reset();
    do_reset();
    apply(5'b0, 5'b0, 1'b0);
    n_vec++;
    if ({grant, xfer} !== {5'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_grant: grant/xfer got %b/%b want 00000/0", grant, xfer);
    end
    n_vec++;
    if ({credit_cnt, credit_err} !== {3'd4, 1'b0}) begin
      n_err++;
      $display("FAIL reset_credit: cnt/err got %0d/%b want 4/0", credit_cnt, credit_err);
    end
    tick();
  endtask

  task test_single_port();
    do_reset();
    apply(5'b00100, 5'b00100, 1'b0);
    n_vec++;
    if (grant !== 5'b0) begin
      n_err++;
      $display("FAIL single_req_cycle: grant got %b want 00000", grant);
    end
    tick();
    apply(5'b00100, 5'b00100, 1'b0);
    n_vec++;
    if ({grant, xfer, credit_cnt} !== {5'b00100, 1'b1, 3'd4}) begin
      n_err++;
      $display("FAIL single_grant: grant/xfer/cnt got %b/%b/%0d want 00100/1/4",
               grant, xfer, credit_cnt);
    end
    tick();
    apply(5'b0, 5'b0, 1'b0);
    n_vec++;
    if ({grant, credit_cnt} !== {5'b0, 3'd3}) begin
      n_err++;
      $display("FAIL single_release: grant/cnt got %b/%0d want 00000/3", grant, credit_cnt);
    end
    tick();
  endtask

  task test_round_robin();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      apply(5'b11111, 5'b11111, 1'b0);
      n_vec++;
      if (grant !== 5'b0) begin
        n_err++;
        $display("FAIL rr_bubble[%0d]: grant got %b want 00000", k, grant);
      end
      tick();
      // Return the credit in the same cycle so the counter stays full.
      apply(5'b11111, 5'b11111, 1'b1);
      n_vec++;
      if ({grant, xfer} !== {rr_seq[k], 1'b1}) begin
        n_err++;
        $display("FAIL rr_grant[%0d]: grant/xfer got %b/%b want %b/1", k, grant, xfer, rr_seq[k]);
      end
      tick();
    end
    apply(5'b0, 5'b0, 1'b0);
    n_vec++;
    if ({grant, credit_cnt, credit_err} !== {5'b0, 3'd4, 1'b0}) begin
      n_err++;
      $display("FAIL rr_end: grant/cnt/err got %b/%0d/%b want 00000/4/0",
               grant, credit_cnt, credit_err);
    end
    tick();
  endtask

  task test_packet_hold();
    do_reset();
    apply(5'b01010, 5'b0, 1'b0);
    tick();
    for (int f = 1; f <= 3; f++) begin
      apply(5'b01010, (f == 3) ? 5'b00010 : 5'b0, 1'b0);
      n_vec++;
      if ({grant, xfer} !== {5'b00010, 1'b1}) begin
        n_err++;
        $display("FAIL hold_flit[%0d]: grant/xfer got %b/%b want 00010/1", f, grant, xfer);
      end
      tick();
      if (f == 1) begin
        // Owner drops req mid-packet while port 3 keeps asking.
        apply(5'b01000, 5'b01000, 1'b0);
        n_vec++;
        if ({grant, xfer} !== {5'b00010, 1'b0}) begin
          n_err++;
          $display("FAIL hold_owner_stall: grant/xfer got %b/%b want 00010/0", grant, xfer);
        end
        tick();
      end
    end
    apply(5'b01000, 5'b01000, 1'b0);
    n_vec++;
    if (grant !== 5'b0) begin
      n_err++;
      $display("FAIL hold_bubble: grant got %b want 00000", grant);
    end
    tick();
    apply(5'b01000, 5'b01000, 1'b0);
    n_vec++;
    if ({grant, xfer, credit_cnt} !== {5'b01000, 1'b1, 3'd1}) begin
      n_err++;
      $display("FAIL hold_next: grant/xfer/cnt got %b/%b/%0d want 01000/1/1",
               grant, xfer, credit_cnt);
    end
    tick();
  endtask

  task test_credit_stall();
    do_reset();
    apply(5'b00001, 5'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(5'b00001, 5'b0, 1'b0);
      n_vec++;
      if ({xfer, credit_cnt} !== {1'b1, 3'(4 - i)}) begin
        n_err++;
        $display("FAIL stall_drain[%0d]: xfer/cnt got %b/%0d want 1/%0d", i, xfer, credit_cnt, 4 - i);
      end
      tick();
    end
    apply(5'b00001, 5'b0, 1'b0);
    n_vec++;
    if ({grant, xfer, credit_cnt} !== {5'b00001, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL stall_empty: grant/xfer/cnt got %b/%b/%0d want 00001/0/0",
               grant, xfer, credit_cnt);
    end
    tick();
    apply(5'b00001, 5'b0, 1'b1);
    n_vec++;
    if (xfer !== 1'b0) begin
      n_err++;
      $display("FAIL stall_pulse_cycle: xfer got %b want 0", xfer);
    end
    tick();
    apply(5'b00001, 5'b0, 1'b0);
    n_vec++;
    if ({xfer, credit_cnt} !== {1'b1, 3'd1}) begin
      n_err++;
      $display("FAIL stall_one_xfer: xfer/cnt got %b/%0d want 1/1", xfer, credit_cnt);
    end
    tick();
    apply(5'b00001, 5'b0, 1'b0);
    n_vec++;
    if ({grant, xfer, credit_cnt} !== {5'b00001, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL stall_again: grant/xfer/cnt got %b/%b/%0d want 00001/0/0",
               grant, xfer, credit_cnt);
    end
    tick();
  endtask

  task test_credit_simul();
    do_reset();
    apply(5'b00010, 5'b0, 1'b0);
    tick();
    apply(5'b00010, 5'b0, 1'b0);
    tick();
    apply(5'b00010, 5'b0, 1'b0);
    tick();
    apply(5'b00010, 5'b0, 1'b1);
    n_vec++;
    if ({xfer, credit_cnt} !== {1'b1, 3'd2}) begin
      n_err++;
      $display("FAIL simul_before: xfer/cnt got %b/%0d want 1/2", xfer, credit_cnt);
    end
    tick();
    apply(5'b0, 5'b0, 1'b0);
    n_vec++;
    if ({grant, xfer, credit_cnt} !== {5'b00010, 1'b0, 3'd2}) begin
      n_err++;
      $display("FAIL simul_after: grant/xfer/cnt got %b/%b/%0d want 00010/0/2",
               grant, xfer, credit_cnt);
    end
    tick();

    do_reset();
    apply(5'b0, 5'b0, 1'b1);
    tick();
    apply(5'b0, 5'b0, 1'b0);
    n_vec++;
    if ({credit_cnt, credit_err} !== {3'd4, 1'b1}) begin
      n_err++;
      $display("FAIL overflow: cnt/err got %0d/%b want 4/1", credit_cnt, credit_err);
    end
    tick();
    repeat (3) tick();
    apply(5'b0, 5'b0, 1'b0);
    n_vec++;
    if (credit_err !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_sticky: err got %b want 1", credit_err);
    end
    tick();
    do_reset();
    apply(5'b0, 5'b0, 1'b0);
    n_vec++;
    if (credit_err !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_cleared: err got %b want 0", credit_err);
    end
    tick();
  endtask

  task test_random();
    logic [4:0] r;
    logic [4:0] t;
    logic       c;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = 5'($urandom);
      t = 5'($urandom) & 5'($urandom);
      c = ($urandom_range(0, 2) == 0);
      apply(r, t, c);
      n_vec++;
      if ({grant, xfer, credit_cnt, credit_err} !== {exp_grant, exp_xfer, exp_cnt, exp_err}) begin
        n_err++;
        $display("FAIL random[%0d]: grant/xfer/cnt/err got %b/%b/%0d/%b want %b/%b/%0d/%b",
                 i, grant, xfer, credit_cnt, credit_err, exp_grant, exp_xfer, exp_cnt, exp_err);
      end
      tick();
    end
  endtask

  task test_async_reset();
    do_reset();
    apply(5'b00100, 5'b0, 1'b0);
    tick();
    apply(5'b00100, 5'b0, 1'b0);
    tick();
    apply(5'b00100, 5'b0, 1'b0);
    n_vec++;
    if ({grant, xfer, credit_cnt} !== {5'b00100, 1'b1, 3'd3}) begin
      n_err++;
      $display("FAIL async_pre: grant/xfer/cnt got %b/%b/%0d want 00100/1/3",
               grant, xfer, credit_cnt);
    end
    // Still well before the next rising edge.
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({grant, xfer, credit_cnt, credit_err} !== {5'b0, 1'b0, 3'd4, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: grant/xfer/cnt/err got %b/%b/%0d/%b want 00000/0/4/0",
               grant, xfer, credit_cnt, credit_err);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    apply(5'b00100, 5'b00100, 1'b0);
    n_vec++;
    if (grant !== 5'b0) begin
      n_err++;
      $display("FAIL async_after: grant got %b want 00000", grant);
    end
    tick();
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    tail = '0;
    cin  = 1'b0;
    model_reset();
    test_reset();
    test_single_port();
    test_round_robin();
    test_packet_hold();
    test_credit_stall();
    test_credit_simul();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
